cute_prog_feeder: RTL and testbench
===================================

Name: cute_prog_feeder

Overview:
Program sequencer that drives the cute processor's instruction port. It holds a small program store and presents instruction and immediate words on DIN. It pulses Run, waits for the processor's done, and follows taken jumps reported on jmp/bus. It sits between the test/host load interface and the cute core, acting as the initiator for the core's DIN/Run/done handshake.

Parameters:
DEPTH, 16, number of 9-bit program words; power of two.
ADDR_W, 4, log2(DEPTH).
TIMEOUT, 15, maximum cycles in WAIT for done before flagging error.
MVI_OP, 3'b001, opcode (word[8:6]) that carries one following immediate word.

Ports:
clk  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
ld_en  input  1  program-store write strobe; honoured only in IDLE.
ld_addr  input  ADDR_W  write address.
ld_data  input  9  write data.
prog_len  input  ADDR_W+1  number of words to execute; sampled on start.
start  input  1  begin execution from address 0; honoured only in IDLE.
done  input  1  processor instruction-complete.
jmp  input  1  processor taken-jump flag, qualified by done.
bus  input  9  processor bus; bus[ADDR_W-1:0] is the jump target when jmp=1.
DIN  output  9  word presented to the processor.
Run  output  1  one-cycle instruction-start strobe.
busy  output  1  high in every state except IDLE.
finished  output  1  one-cycle pulse on normal completion.
err  output  1  sticky timeout flag; cleared by start or reset.
pc  output  ADDR_W  current program address.

Behaviour:
- Reset (async, Resetn=0): state=IDLE, DIN=0, Run=0, busy=0, finished=0, err=0, pc=0, len_q=0, timeout counter=0. Program store contents are not reset.
- IDLE:
  - ld_en writes mem[ld_addr]=ld_data on the clock edge. ld_en is ignored outside IDLE.
  - start: pc<=0, len_q<=prog_len, err<=0.
  - If prog_len==0: finished pulses next cycle, state stays IDLE.
  - Otherwise go to ISSUE.
  - If start and ld_en are both high, the write happens and execution starts; the written word is visible to the first ISSUE.
- ISSUE (1 cycle): DIN=mem[pc], Run=1. If mem[pc][8:6]==MVI_OP go to IMM, else WAIT. pc is not advanced yet.
- IMM (1 cycle): DIN=mem[pc+1] (wraps modulo DEPTH), Run=0. Set imm_flag and go to WAIT.
- WAIT: DIN holds its last value, Run=0, and the counter increments each cycle.
  - done=1 with jmp=1: pc<=bus[ADDR_W-1:0] and go to NEXT.
  - done=1 with jmp=0: pc<=pc+1+imm_flag (modulo DEPTH) and go to NEXT.
  - Counter reaching TIMEOUT with no done: err<=1, go to IDLE, no finished pulse.
  - done is ignored in every other state.
- NEXT (1 cycle): exec_cnt<=exec_cnt+1+imm_flag, clear imm_flag and the counter.
  - If exec_cnt (updated) >= len_q: finished=1, go to IDLE.
  - Else go to ISSUE.
  - Jumps still consume length, so a backward-jump loop always terminates.
- Latency: non-MVI instruction issue to next Run is 3 cycles plus the processor's done latency. MVI adds 1 cycle.
- Run never asserts on two consecutive cycles.
- Reset mid-operation aborts immediately. Run drops asynchronously, and no finished or err pulse is produced.

Decomposition:
- Shared package cute_pkg:
  - opcode localparams (MVI_OP and the others used by the core's FSM);
  - feeder state encoding {IDLE, ISSUE, IMM, WAIT, NEXT};
  - the data width constant WORD_W=9.
- One sub-module: cute_prog_mem.
  - DEPTH x 9 register file.
  - One synchronous write port and two combinational read ports (pc, pc+1).
  - No reset.

Test Plan:
1. Load mem[0]=9'o000 (mv), prog_len=1; start; done after 3 cycles, jmp=0 -> one Run pulse with DIN=9'o000, pc goes 0->1, finished pulses once, busy then drops.
2. Load mem[0]=9'o100 (mvi), mem[1]=9'd77, mem[2]=9'o000, prog_len=3; respond done each instruction -> Run with DIN=9'o100, next cycle DIN=77 with Run=0, then Run with DIN=9'o000; pc sequence 0,2,3; finished pulses.
3. prog_len=4; on the first instruction's done drive jmp=1, bus=9'd3 -> next Run presents mem[3], pc=3; finished after exec count reaches 4.
4. Start, then never assert done -> after TIMEOUT=15 WAIT cycles err=1, state IDLE, finished never pulses; a new start clears err.
5. prog_len=0 start -> no Run, finished pulses next cycle. ld_en during busy is ignored (mem read back unchanged after run).
6. Deassert Resetn during WAIT -> Run=0, DIN=0, busy=0, pc=0 immediately. After release, start runs the program from address 0 correctly.

Source files
------------

// File: rtl/cute_pkg.sv
// Shared definitions for the cute core and its program feeder.
//   WORD_W        : width of instruction/immediate/bus words
//   OP_*          : 3-bit opcodes found in word[8:6]
//   feeder_state_t: sequencer states of cute_prog_feeder
package cute_pkg;

  localparam int WORD_W = 9;

  // Opcodes decoded by the core; only OP_MVI matters to the feeder because
  // it is the one instruction followed by an immediate word.
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    IMM   = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/cute_prog_mem.sv
// Program store for the feeder: DEPTH x WORD_W register file, no reset.
//   clk     : write clock
//   we      : write strobe
//   waddr   : write address
//   wdata   : write data
//   raddr_a : read port A address (current pc)
//   rdata_a : read port A data, combinational
//   raddr_b : read port B address (pc + 1, immediate word)
//   rdata_b : read port B data, combinational
module cute_prog_mem
  import cute_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem_reg [DEPTH];

  // Both read ports are combinational, so the store is a plain register
  // file rather than a block RAM; each word decodes its own write enable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (we && (waddr == ADDR_W'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  assign rdata_a = mem_reg[raddr_a];
  assign rdata_b = mem_reg[raddr_b];

endmodule

// File: rtl/cute_prog_feeder.sv
// Program sequencer driving the cute core's DIN/Run/done handshake.
//   clk, Resetn : clock (rising edge) and async active-low reset
//   ld_en/ld_addr/ld_data : program-store write port (IDLE only)
//   prog_len    : number of words to execute, sampled on start
//   start       : begin execution at address 0 (IDLE only)
//   done/jmp/bus: completion, taken-jump flag and jump target from the core
//   DIN         : word presented to the core
//   Run         : one-cycle instruction-start strobe
//   busy        : high outside IDLE
//   finished    : one-cycle pulse on normal completion
//   err         : sticky timeout flag, cleared by start
//   pc          : current program address
module cute_prog_feeder
  import cute_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 15,
  parameter logic [2:0] MVI_OP  = OP_MVI
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              done,
  input  logic              jmp,
  input  logic [WORD_W-1:0] bus,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic              busy,
  output logic              finished,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  feeder_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W:0]   len_reg, len_next;
  // One bit wider than prog_len: an MVI as the last word may push the
  // executed count one past the maximum length.
  logic [ADDR_W+1:0] exec_reg, exec_next, exec_inc;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              imm_reg, imm_next;
  logic              err_reg, err_next;
  logic              zfin_reg, zfin_next;
  logic [WORD_W-1:0] din_reg, din_next;
  logic              fin_now;
  logic              mem_we;
  logic [WORD_W-1:0] word_cur, word_imm;
  logic              unused_bus;

  assign unused_bus = ^bus[WORD_W-1:ADDR_W];
  assign mem_we     = ld_en && (state_reg == IDLE);

  cute_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (ld_addr),
    .wdata   (ld_data),
    .raddr_a (pc_reg),
    .rdata_a (word_cur),
    .raddr_b (pc_reg + ADDR_W'(1)),
    .rdata_b (word_imm)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      len_reg   <= '0;
      exec_reg  <= '0;
      cnt_reg   <= '0;
      imm_reg   <= 1'b0;
      err_reg   <= 1'b0;
      zfin_reg  <= 1'b0;
      din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      len_reg   <= len_next;
      exec_reg  <= exec_next;
      cnt_reg   <= cnt_next;
      imm_reg   <= imm_next;
      err_reg   <= err_next;
      zfin_reg  <= zfin_next;
      din_reg   <= din_next;
    end
  end

  assign exec_inc = exec_reg + (ADDR_W+2)'(1) + (ADDR_W+2)'(imm_reg);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    exec_next  = exec_reg;
    cnt_next   = cnt_reg;
    imm_next   = imm_reg;
    err_next   = err_reg;
    zfin_next  = 1'b0;
    din_next   = din_reg;
    fin_now    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next   = '0;
          len_next  = prog_len;
          exec_next = '0;
          cnt_next  = '0;
          imm_next  = 1'b0;
          err_next  = 1'b0;
          // An empty program completes without ever touching the core.
          if (prog_len == '0) begin
            zfin_next = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        din_next   = word_cur;
        state_next = (word_cur[WORD_W-1:WORD_W-3] == MVI_OP) ? IMM : WAIT;
      end

      IMM: begin
        din_next   = word_imm;
        imm_next   = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
        if (done) begin
          pc_next    = jmp ? bus[ADDR_W-1:0]
                           : pc_reg + ADDR_W'(1) + ADDR_W'(imm_reg);
          state_next = NEXT;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without done: give up.
          err_next   = 1'b1;
          cnt_next   = '0;
          imm_next   = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      NEXT: begin
        exec_next = exec_inc;
        imm_next  = 1'b0;
        cnt_next  = '0;
        // Taken jumps still consume length, so any loop terminates.
        if (exec_inc >= {1'b0, len_reg}) begin
          fin_now    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ISSUE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Run and DIN come straight from the state register so a reset drops
  // them immediately; outside ISSUE/IMM the last presented word is held.
  assign Run      = (state_reg == ISSUE);
  assign DIN      = (state_reg == ISSUE) ? word_cur :
                    (state_reg == IMM)   ? word_imm : din_reg;
  assign busy     = (state_reg != IDLE);
  assign finished = fin_now | zfin_reg;
  assign err      = err_reg;
  assign pc       = pc_reg;

endmodule

// File: tb/tb_cute_prog_feeder.sv
`timescale 1ns/1ps
module tb_cute_prog_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          Resetn = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [8:0]    ld_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic          jmp = 1'b0;
  logic [8:0]    bus = '0;
  logic [8:0]    DIN;
  logic          Run, busy, finished, err;
  logic [AW-1:0] pc;

  cute_prog_feeder #(
    .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(15), .MVI_OP(3'b001)
  ) dut (
    .clk(clk), .Resetn(Resetn), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .prog_len(prog_len), .start(start), .done(done),
    .jmp(jmp), .bus(bus), .DIN(DIN), .Run(Run), .busy(busy),
    .finished(finished), .err(err), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]    din;
    logic [AW-1:0] pc;
    logic          mvi;
    logic [8:0]    imm;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;
  int fin_cnt  = 0;
  int run_cnt  = 0;
  int resp_idx = 0;
  int resp_lat = 3;
  int jmp_run  = -1;
  logic [AW-1:0] jmp_tgt = '0;
  bit resp_en = 1'b1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Scoreboard consumer: every Run pops one expected instruction.
  initial begin : monitor
    exp_t e;
    logic prev_run;
    prev_run = 1'b0;
    forever begin
      @(negedge clk);
      if (finished === 1'b1) fin_cnt++;
      if (Run === 1'b1) begin
        run_cnt++;
        check("run_spacing", prev_run, 0);
        check("run_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("run_din", DIN, e.din);
          check("run_pc", pc, e.pc);
          if (e.mvi) begin
            @(negedge clk);
            check("imm_run_low", Run, 0);
            check("imm_din", DIN, e.imm);
          end
        end
      end
      prev_run = Run;
    end
  end

  // Core stand-in: answers each Run with done after resp_lat cycles.
  initial begin : responder
    int idx;
    forever begin
      @(negedge clk);
      if (Run === 1'b1 && resp_en) begin
        idx = resp_idx;
        resp_idx++;
        repeat (resp_lat) @(negedge clk);
        done = 1'b1;
        if (idx == jmp_run) begin
          jmp = 1'b1;
          bus = {5'($urandom), jmp_tgt};
        end else begin
          jmp = 1'b0;
          bus = 9'($urandom);
        end
        @(negedge clk);
        done = 1'b0;
        jmp  = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(int a, logic [8:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Producer: walks the bench's own copy of the program and queues the
  // instruction stream the feeder should present.
  task automatic model_push(int len, int joff, int tgt, output logic [AW-1:0] pc_end);
    int p, ex, k;
    exp_t e;
    p = 0; ex = 0; k = 0;
    while (ex < len) begin
      e.din = model_mem[p];
      e.pc  = AW'(p);
      e.mvi = (model_mem[p][8:6] == 3'b001);
      e.imm = model_mem[(p + 1) % DEPTH];
      sb.push_back(e);
      if (k == joff) p = tgt;
      else           p = (p + 1 + int'(e.mvi)) % DEPTH;
      ex += 1 + int'(e.mvi);
      k++;
    end
    pc_end = AW'(p);
  endtask

  task automatic run_prog(string name, int len, int joff, int tgt, bit poke);
    logic [AW-1:0] pc_end;
    int f0;
    model_push(len, joff, tgt, pc_end);
    jmp_run  = (joff < 0) ? -1 : resp_idx + joff;
    jmp_tgt  = AW'(tgt);
    f0       = fin_cnt;
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = '0; ld_data = 9'o777;
      @(negedge clk);
      ld_en = 1'b0;
    end
    for (int k = 0; k < 400; k++) begin
      if (fin_cnt != f0) break;
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_fin"}, fin_cnt - f0, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_pc"}, pc, pc_end);
    check({name, "_left"}, sb.size(), 0);
    check({name, "_err"}, err, 0);
  endtask

  initial begin : stim
    logic [AW-1:0] pe;
    int f0, n, r0;
    #1 Resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", finished, 0);
    check("rst_err", err, 0);
    check("rst_pc", pc, 0);
    Resetn = 1'b1;
    @(negedge clk);

    // single mv
    load(0, 9'o000);
    run_prog("t1_mv", 1, -1, 0, 1'b0);

    // mvi + immediate, then mv
    load(0, 9'o100); load(1, 9'd77); load(2, 9'o000);
    run_prog("t2_mvi", 3, -1, 0, 1'b0);

    // taken jump on the first instruction
    load(0, 9'o000); load(3, 9'o021); load(4, 9'o200); load(5, 9'o310);
    run_prog("t3_jmp", 4, 0, 3, 1'b0);

    // timeout: core never answers
    resp_en = 1'b0;
    model_push(1, -1, 0, pe);
    f0 = fin_cnt;
    prog_len = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("to_busy_cycles", n, 16);
    check("to_err", err, 1);
    repeat (2) @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_no_fin", fin_cnt - f0, 0);
    check("to_left", sb.size(), 0);
    resp_en = 1'b1;

    // zero-length program: finished next cycle, err cleared
    prog_len = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_fin", finished, 1);
    check("zero_busy", busy, 0);
    check("zero_err_clr", err, 0);
    check("zero_run", Run, 0);
    @(negedge clk);
    check("zero_fin_end", finished, 0);

    // writes while busy must be dropped
    load(0, 9'o234);
    resp_lat = 6;
    run_prog("busy_ld", 1, -1, 0, 1'b1);
    resp_lat = 3;
    run_prog("readback", 1, -1, 0, 1'b0);

    // reset in the middle of WAIT
    load(0, 9'o010); load(1, 9'o020); load(2, 9'o030);
    resp_lat = 5;
    model_push(3, -1, 0, pe);
    r0 = run_cnt;
    prog_len = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (run_cnt < r0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_runs", run_cnt - r0, 2);
    @(negedge clk);
    check("mid_pc", pc, 1);
    check("mid_busy", busy, 1);
    Resetn = 1'b0;
    #1;
    check("arst_run", Run, 0);
    check("arst_din", DIN, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc, 0);
    check("arst_fin", finished, 0);
    check("arst_err", err, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    repeat (10) @(negedge clk);
    resp_lat = 3;
    run_prog("after_rst", 1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
